// File: rtl/mpi_eth_pkg.sv
// Shared definitions for the MPI/Ethernet receive parser: parser states,
// header type codes and the bit offsets of every header field within its beat.
package mpi_eth_pkg;

  typedef enum logic [2:0] {
    H0      = 3'd0,
    H1      = 3'd1,
    H2      = 3'd2,
    H3      = 3'd3,
    PAYLOAD = 3'd4,
    DROP    = 3'd5
  } state_t;

  localparam logic [15:0] HDR_TYPE_ETH = 16'd1;
  localparam logic [15:0] HDR_TYPE_MPI = 16'd2;

  // beat0 / beat1
  localparam int MAC_LSB      = 0;
  localparam int RANK_LSB     = 48;
  localparam int TYPE_LSB     = 48;
  // beat2
  localparam int PKT_TYPE_LSB = 0;
  localparam int SRC_RANK_LSB = 8;
  localparam int TAG_LSB      = 16;
  localparam int SIZE_LSB     = 32;
  // beat3
  localparam int IP_DST_LSB   = 0;
  localparam int IP_SRC_LSB   = 32;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage stream register: one cycle of latency, full throughput, and the
// output beat is held until the downstream side accepts it.
module axis_reg_slice (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_keep,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  logic load;

  // The register can take a new beat when it is empty or is being drained now.
  assign in_ready = aresetn && (!out_valid || out_ready);
  assign load     = in_valid && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mpi_eth_rx_parser.sv
// Receive-side parser: strips the ETH/MPI header, publishes its fields, filters
// frames by rank and forwards the payload through a register slice.
module mpi_eth_rx_parser
  import mpi_eth_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter bit FILTER_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [63:0]          stream_in_DATA,
  input  logic [7:0]           stream_in_KEEP,
  input  logic                 stream_in_LAST,
  input  logic                 stream_in_VALID,
  output logic                 stream_in_READY,
  output logic [63:0]          stream_out_DATA,
  output logic [7:0]           stream_out_KEEP,
  output logic                 stream_out_LAST,
  output logic                 stream_out_VALID,
  input  logic                 stream_out_READY,
  input  logic [15:0]          my_rank,
  output logic                 hdr_valid,
  output logic [15:0]          hdr_type,
  output logic [47:0]          mac_dst,
  output logic [47:0]          mac_src,
  output logic [15:0]          dst_rank,
  output logic [7:0]           src_rank,
  output logic [7:0]           packet_type,
  output logic [7:0]           tag,
  output logic [31:0]          size,
  output logic [31:0]          ip_dst,
  output logic [31:0]          ip_src,
  output logic                 err_short,
  output logic                 err_type,
  output logic [CNT_WIDTH-1:0] frames_ok,
  output logic [CNT_WIDTH-1:0] frames_dropped
);

  state_t state, next_state;

  logic        slice_ready, in_acc, filter_miss, out_last_done;
  logic        pub_eth, pub_mpi, set_err_short, set_err_type, inc_drop, inc_ok_hdr;
  logic [15:0] beat_type;

  logic [47:0] sh_mac_dst, sh_mac_src;
  logic [15:0] sh_dst_rank, sh_type;
  logic [7:0]  sh_pkt_type, sh_src_rank, sh_tag;
  logic [31:0] sh_size;
  logic        sh_rank_miss;

  assign stream_in_READY = aresetn && ((state == PAYLOAD) ? slice_ready : 1'b1);
  assign in_acc          = stream_in_VALID && stream_in_READY;
  assign beat_type       = stream_in_DATA[TYPE_LSB +: 16];
  assign filter_miss     = FILTER_EN && sh_rank_miss;
  assign out_last_done   = stream_out_VALID && stream_out_READY && stream_out_LAST;

  axis_reg_slice u_slice (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_data   (stream_in_DATA),
    .in_keep   (stream_in_KEEP),
    .in_last   (stream_in_LAST),
    .in_valid  (stream_in_VALID && (state == PAYLOAD)),
    .in_ready  (slice_ready),
    .out_data  (stream_out_DATA),
    .out_keep  (stream_out_KEEP),
    .out_last  (stream_out_LAST),
    .out_valid (stream_out_VALID),
    .out_ready (stream_out_READY)
  );

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0] n);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, n};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= H0;
    else          state <= next_state;
  end

  always_comb begin
    next_state    = state;
    pub_eth       = 1'b0;
    pub_mpi       = 1'b0;
    set_err_short = 1'b0;
    set_err_type  = 1'b0;
    inc_drop      = 1'b0;
    inc_ok_hdr    = 1'b0;
    if (in_acc) begin
      case (state)
        H0: begin
          if (stream_in_LAST) begin
            set_err_short = 1'b1;
            inc_drop      = 1'b1;
          end else begin
            next_state = H1;
          end
        end
        H1: begin
          if (beat_type == HDR_TYPE_MPI) begin
            if (stream_in_LAST) begin
              set_err_short = 1'b1;
              inc_drop      = 1'b1;
              next_state    = H0;
            end else begin
              next_state = H2;
            end
          end else if (beat_type == HDR_TYPE_ETH) begin
            if (filter_miss) begin
              inc_drop   = stream_in_LAST;
              next_state = stream_in_LAST ? H0 : DROP;
            end else begin
              pub_eth    = 1'b1;
              inc_ok_hdr = stream_in_LAST;
              next_state = stream_in_LAST ? H0 : PAYLOAD;
            end
          end else begin
            set_err_type = 1'b1;
            inc_drop     = stream_in_LAST;
            next_state   = stream_in_LAST ? H0 : DROP;
          end
        end
        H2: begin
          if (stream_in_LAST) begin
            set_err_short = 1'b1;
            inc_drop      = 1'b1;
            next_state    = H0;
          end else begin
            next_state = H3;
          end
        end
        H3: begin
          if (filter_miss) begin
            inc_drop   = stream_in_LAST;
            next_state = stream_in_LAST ? H0 : DROP;
          end else begin
            pub_mpi    = 1'b1;
            inc_ok_hdr = stream_in_LAST;
            next_state = stream_in_LAST ? H0 : PAYLOAD;
          end
        end
        PAYLOAD: if (stream_in_LAST) next_state = H0;
        DROP: begin
          if (stream_in_LAST) begin
            inc_drop   = 1'b1;
            next_state = H0;
          end
        end
        default: next_state = H0;
      endcase
    end
  end

  // Header beats land in shadow registers; the visible fields only change together with hdr_valid.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sh_mac_dst   <= '0;
      sh_dst_rank  <= '0;
      sh_rank_miss <= 1'b0;
      sh_mac_src   <= '0;
      sh_type      <= '0;
      sh_pkt_type  <= '0;
      sh_src_rank  <= '0;
      sh_tag       <= '0;
      sh_size      <= '0;
      hdr_valid    <= 1'b0;
      err_short    <= 1'b0;
      err_type     <= 1'b0;
      hdr_type     <= '0;
      mac_dst      <= '0;
      mac_src      <= '0;
      dst_rank     <= '0;
      src_rank     <= '0;
      packet_type  <= '0;
      tag          <= '0;
      size         <= '0;
      ip_dst       <= '0;
      ip_src       <= '0;
      frames_ok      <= '0;
      frames_dropped <= '0;
    end else begin
      hdr_valid <= pub_eth || pub_mpi;
      err_short <= set_err_short;
      err_type  <= set_err_type;
      if (in_acc && state == H0) begin
        sh_mac_dst   <= stream_in_DATA[MAC_LSB +: 48];
        sh_dst_rank  <= stream_in_DATA[RANK_LSB +: 16];
        sh_rank_miss <= stream_in_DATA[RANK_LSB +: 16] != my_rank;
      end
      if (in_acc && state == H1) begin
        sh_mac_src <= stream_in_DATA[MAC_LSB +: 48];
        sh_type    <= beat_type;
      end
      if (in_acc && state == H2) begin
        sh_pkt_type <= stream_in_DATA[PKT_TYPE_LSB +: 8];
        sh_src_rank <= stream_in_DATA[SRC_RANK_LSB +: 8];
        sh_tag      <= stream_in_DATA[TAG_LSB +: 8];
        sh_size     <= stream_in_DATA[SIZE_LSB +: 32];
      end
      if (pub_eth) begin
        mac_dst     <= sh_mac_dst;
        dst_rank    <= sh_dst_rank;
        mac_src     <= stream_in_DATA[MAC_LSB +: 48];
        hdr_type    <= beat_type;
        packet_type <= '0;
        src_rank    <= '0;
        tag         <= '0;
        size        <= '0;
        ip_dst      <= '0;
        ip_src      <= '0;
      end
      if (pub_mpi) begin
        mac_dst     <= sh_mac_dst;
        dst_rank    <= sh_dst_rank;
        mac_src     <= sh_mac_src;
        hdr_type    <= sh_type;
        packet_type <= sh_pkt_type;
        src_rank    <= sh_src_rank;
        tag         <= sh_tag;
        size        <= sh_size;
        ip_dst      <= stream_in_DATA[IP_DST_LSB +: 32];
        ip_src      <= stream_in_DATA[IP_SRC_LSB +: 32];
      end
      // A zero-payload frame can complete while the previous frame's LAST drains, so add up to two.
      frames_ok      <= sat_add(frames_ok, {1'b0, inc_ok_hdr} + {1'b0, out_last_done});
      frames_dropped <= sat_add(frames_dropped, {1'b0, inc_drop});
    end
  end

endmodule

// File: tb/tb_mpi_eth_rx_parser.sv
// Directed self-checking bench for mpi_eth_rx_parser with a payload scoreboard
// and a monitor tallying header/error pulses.
module tb_mpi_eth_rx_parser;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [63:0]   stream_in_DATA = '0;
  logic [7:0]    stream_in_KEEP = '0;
  logic          stream_in_LAST = 1'b0;
  logic          stream_in_VALID = 1'b0;
  logic          stream_in_READY;
  logic [63:0]   stream_out_DATA;
  logic [7:0]    stream_out_KEEP;
  logic          stream_out_LAST;
  logic          stream_out_VALID;
  logic          stream_out_READY = 1'b1;
  logic [15:0]   my_rank = 16'd1;
  logic          hdr_valid;
  logic [15:0]   hdr_type;
  logic [47:0]   mac_dst, mac_src;
  logic [15:0]   dst_rank;
  logic [7:0]    src_rank, packet_type, tag;
  logic [31:0]   size, ip_dst, ip_src;
  logic          err_short, err_type;
  logic [CW-1:0] frames_ok, frames_dropped;

  mpi_eth_rx_parser #(.CNT_WIDTH(CW), .FILTER_EN(1'b1)) dut (
    .clk(clk), .aresetn(aresetn),
    .stream_in_DATA(stream_in_DATA), .stream_in_KEEP(stream_in_KEEP),
    .stream_in_LAST(stream_in_LAST), .stream_in_VALID(stream_in_VALID),
    .stream_in_READY(stream_in_READY),
    .stream_out_DATA(stream_out_DATA), .stream_out_KEEP(stream_out_KEEP),
    .stream_out_LAST(stream_out_LAST), .stream_out_VALID(stream_out_VALID),
    .stream_out_READY(stream_out_READY),
    .my_rank(my_rank), .hdr_valid(hdr_valid), .hdr_type(hdr_type),
    .mac_dst(mac_dst), .mac_src(mac_src), .dst_rank(dst_rank),
    .src_rank(src_rank), .packet_type(packet_type), .tag(tag), .size(size),
    .ip_dst(ip_dst), .ip_src(ip_src), .err_short(err_short), .err_type(err_type),
    .frames_ok(frames_ok), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int hdr_cnt = 0, es_cnt = 0, et_cnt = 0, hdr_snap = 0;
  bit chk_stall = 1'b0;
  bit tog = 1'b0;
  logic [15:0] cap_type, cap_dst_rank;
  logic [47:0] cap_mac_dst, cap_mac_src;
  logic [7:0]  cap_src_rank, cap_pkt, cap_tag;
  logic [31:0] cap_size, cap_ip_dst, cap_ip_src;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Scoreboard and pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    beat_t e;
    beat_t o;
    if (hdr_valid) begin
      hdr_cnt++;
      cap_type = hdr_type; cap_dst_rank = dst_rank;
      cap_mac_dst = mac_dst; cap_mac_src = mac_src;
      cap_src_rank = src_rank; cap_pkt = packet_type; cap_tag = tag;
      cap_size = size; cap_ip_dst = ip_dst; cap_ip_src = ip_src;
    end
    if (err_short) es_cnt++;
    if (err_type)  et_cnt++;
    if (aresetn && stream_out_VALID && stream_out_READY) begin
      o = {stream_out_DATA, stream_out_KEEP, stream_out_LAST};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_beat: observed %0h expected none", o);
      end else begin
        e = exp_q.pop_front();
        assert (o === e)
        else begin
          errors++;
          $error("FAIL payload_beat: observed %0h expected %0h", o, e);
        end
      end
    end
    if (chk_stall && stream_out_VALID && !stream_out_READY) begin
      checks++;
      assert (stream_in_READY === 1'b0)
      else begin
        errors++;
        $error("FAIL in_ready_stall: observed %0b expected 0", stream_in_READY);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog) stream_out_READY = ~stream_out_READY;
    end
  end

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k,
                               input logic l, input bit pay);
    int n;
    n = 0;
    stream_in_DATA = d; stream_in_KEEP = k; stream_in_LAST = l; stream_in_VALID = 1'b1;
    @(negedge clk);
    while (!stream_in_READY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!stream_in_READY) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed ready 0 expected 1 within 100 cycles");
    end else if (pay) begin
      exp_q.push_back({d, k, l});
    end
    @(posedge clk);
    #1;
    stream_in_VALID = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", stream_out_VALID, 0);
    chk("rst_in_ready", stream_in_READY, 0);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_mac_dst", mac_dst, 0);
    chk("rst_frames_ok", frames_ok, 0);
    @(negedge clk) aresetn = 1'b1;
    wait_cycles(2);

    // MPI frame, two payload beats
    applyStimulus({16'd1, 48'h0A0B0C0D0E0F}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({16'd2, 48'h112233445566}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({32'd16, 8'h00, 8'h33, 8'h00, 8'h05}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({32'h0A000002, 32'h0A000001}, 8'hFF, 1'b0, 1'b0);
    chk("mpi_hdr_latency", hdr_valid, 1);
    applyStimulus(64'hDEADBEEF00000001, 8'hFF, 1'b0, 1'b1);
    applyStimulus(64'hDEADBEEF00000002, 8'h0F, 1'b1, 1'b1);
    wait_cycles(5);
    chk("mpi_hdr_count", hdr_cnt, 1);
    chk("mpi_type", cap_type, 2);
    chk("mpi_mac_dst", cap_mac_dst, 48'h0A0B0C0D0E0F);
    chk("mpi_mac_src", cap_mac_src, 48'h112233445566);
    chk("mpi_dst_rank", cap_dst_rank, 1);
    chk("mpi_src_rank", cap_src_rank, 0);
    chk("mpi_pkt_type", cap_pkt, 8'h05);
    chk("mpi_tag", cap_tag, 8'h33);
    chk("mpi_size", cap_size, 16);
    chk("mpi_ip_dst", cap_ip_dst, 32'h0A000001);
    chk("mpi_ip_src", cap_ip_src, 32'h0A000002);
    chk("mpi_frames_ok", frames_ok, 1);
    chk("mpi_queue_empty", exp_q.size(), 0);

    // ETH frame, three payload beats against a toggling egress
    applyStimulus({16'd1, 48'hAAAA0000BBBB}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({16'd1, 48'hCCCC0000DDDD}, 8'hFF, 1'b0, 1'b0);
    chk_stall = 1'b1;
    tog = 1'b1;
    applyStimulus(64'h1111111111111111, 8'hFF, 1'b0, 1'b1);
    applyStimulus(64'h2222222222222222, 8'hFF, 1'b0, 1'b1);
    applyStimulus(64'h3333333333333333, 8'h03, 1'b1, 1'b1);
    chk_stall = 1'b0;
    wait_cycles(10);
    tog = 1'b0;
    stream_out_READY = 1'b1;
    wait_cycles(3);
    chk("eth_hdr_count", hdr_cnt, 2);
    chk("eth_type", cap_type, 1);
    chk("eth_mac_src", cap_mac_src, 48'hCCCC0000DDDD);
    chk("eth_frames_ok", frames_ok, 2);
    chk("eth_queue_empty", exp_q.size(), 0);

    // Short MPI frame ending on beat1, then a good ETH frame
    applyStimulus({16'd1, 48'h010203040506}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({16'd2, 48'h0708090A0B0C}, 8'hFF, 1'b1, 1'b0);
    chk("short_err_pulse", err_short, 1);
    wait_cycles(3);
    chk("short_err_count", es_cnt, 1);
    chk("short_no_hdr", hdr_cnt, 2);
    chk("short_dropped", frames_dropped, 1);
    applyStimulus({16'd1, 48'h5555AAAA5555}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({16'd1, 48'h6666BBBB6666}, 8'hFF, 1'b0, 1'b0);
    applyStimulus(64'h4444444444444444, 8'hFF, 1'b1, 1'b1);
    wait_cycles(4);
    chk("after_short_hdr", hdr_cnt, 3);
    chk("after_short_mac_dst", cap_mac_dst, 48'h5555AAAA5555);
    chk("after_short_ok", frames_ok, 3);

    // Rank filter: dst_rank 5 against my_rank 1
    applyStimulus({16'd5, 48'h0000000000F5}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({16'd2, 48'h0000000000F6}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({32'd8, 8'h00, 8'h01, 8'h02, 8'h03}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({32'h01020304, 32'h05060708}, 8'hFF, 1'b0, 1'b0);
    applyStimulus(64'h7777777777777777, 8'hFF, 1'b1, 1'b0);
    wait_cycles(4);
    chk("filter_no_hdr", hdr_cnt, 3);
    chk("filter_dropped", frames_dropped, 2);
    chk("filter_ok_same", frames_ok, 3);

    // Unknown header type
    applyStimulus({16'd1, 48'h000000000011}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({16'd7, 48'h000000000022}, 8'hFF, 1'b0, 1'b0);
    chk("type_err_pulse", err_type, 1);
    applyStimulus(64'h8888888888888888, 8'hFF, 1'b1, 1'b0);
    wait_cycles(4);
    chk("type_err_count", et_cnt, 1);
    chk("type_dropped", frames_dropped, 3);
    chk("type_no_hdr", hdr_cnt, 3);

    // Zero-payload ETH frame
    applyStimulus({16'd1, 48'h000000000033}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({16'd1, 48'h000000000044}, 8'hFF, 1'b1, 1'b0);
    wait_cycles(3);
    chk("zero_pay_hdr", hdr_cnt, 4);
    chk("zero_pay_ok", frames_ok, 4);
    chk("zero_pay_queue", exp_q.size(), 0);

    // Reset while a payload beat sits in the output register
    stream_out_READY = 1'b0;
    applyStimulus({16'd1, 48'h000000000055}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({16'd2, 48'h000000000066}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({32'd4, 8'h00, 8'h01, 8'h01, 8'h01}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({32'h11111111, 32'h22222222}, 8'hFF, 1'b0, 1'b0);
    applyStimulus(64'h9999999999999999, 8'hFF, 1'b0, 1'b0);
    @(negedge clk) aresetn = 1'b0;
    #2;
    chk("reset_out_valid", stream_out_VALID, 0);
    chk("reset_in_ready", stream_in_READY, 0);
    chk("reset_hdr_valid", hdr_valid, 0);
    chk("reset_errs", {err_short, err_type}, 0);
    chk("reset_fields", {dst_rank, size, mac_dst}, 0);
    chk("reset_counters", {frames_ok, frames_dropped}, 0);
    exp_q.delete();
    wait_cycles(2);
    @(negedge clk) aresetn = 1'b1;
    stream_out_READY = 1'b1;
    wait_cycles(1);
    hdr_snap = hdr_cnt;
    applyStimulus({16'd1, 48'hFEDCBA987654}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({16'd2, 48'h123456789ABC}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({32'd64, 8'h00, 8'h07, 8'h03, 8'h09}, 8'hFF, 1'b0, 1'b0);
    applyStimulus({32'hC0A80002, 32'hC0A80001}, 8'hFF, 1'b0, 1'b0);
    applyStimulus(64'hABCDEF0123456789, 8'hF0, 1'b1, 1'b1);
    wait_cycles(4);
    chk("post_rst_hdr", hdr_cnt - hdr_snap, 1);
    chk("post_rst_mac_dst", cap_mac_dst, 48'hFEDCBA987654);
    chk("post_rst_src_rank", cap_src_rank, 3);
    chk("post_rst_tag", cap_tag, 7);
    chk("post_rst_pkt", cap_pkt, 9);
    chk("post_rst_size", cap_size, 64);
    chk("post_rst_ip_dst", cap_ip_dst, 32'hC0A80001);
    chk("post_rst_ok", frames_ok, 1);

    // frames_dropped saturation with single-beat short frames
    for (int i = 0; i < 20; i++) applyStimulus(64'h0, 8'hFF, 1'b1, 1'b0);
    wait_cycles(3);
    chk("sat_dropped", frames_dropped, 4'hF);
    chk("sat_ok_same", frames_ok, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpi_eth_rx_parser.md
MPI_ETH_RX_PARSER -- requirements
Module: mpi_eth_rx_parser

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- CNT_WIDTH, 32, width of the frame counters.
- FILTER_EN, 1, enables dropping of frames whose dst_rank differs from my_rank.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; one clock, all logic on its rising edge.
- aresetn, in, 1, reset; asynchronous, active-low.
- stream_in_DATA / stream_in_KEEP / stream_in_LAST / stream_in_VALID, in, 64/8/1/1, ingress stream.
- stream_in_READY, out, 1, ingress ready.
- stream_out_DATA / stream_out_KEEP / stream_out_LAST / stream_out_VALID, out, 64/8/1/1, payload egress stream.
- stream_out_READY, in, 1, egress ready.
- my_rank, in, 16, local rank used by the filter.
- hdr_valid, out, 1, one-cycle pulse when a header has been accepted.
- hdr_type, out, 16, 1 = ETH, 2 = MPI.
- mac_dst / mac_src, out, 48 each, MAC addresses.
- dst_rank, out, 16, destination rank.
- src_rank / packet_type / tag, out, 8 each, MPI fields.
- size, out, 32, MPI payload size.
- ip_dst / ip_src, out, 32 each, IP addresses.
- err_short / err_type, out, 1 each, one-cycle error pulses.
- frames_ok / frames_dropped, out, CNT_WIDTH each, frame counters.

Function
REQ-003 The frame layout SHALL be fixed:
- beat0: [47:0] = mac_dst, [63:48] = dst_rank.
- beat1: [47:0] = mac_src, [63:48] = hdr_type.
- MPI only, beat2: [7:0] = packet_type, [15:8] = src_rank, [23:16] = tag, [31:24] = reserved, [63:32] = size.
- MPI only, beat3: [31:0] = ip_dst, [63:32] = ip_src.
- Payload beats follow until LAST.
REQ-004 The state machine SHALL have states H0, H1, H2, H3, PAYLOAD, DROP; reset state is H0.
REQ-005 Transitions SHALL be, each on an accepted beat:
- H0 -> H1.
- H1 -> H2 if type = 2; -> PAYLOAD if type = 1; -> DROP otherwise, pulsing err_type.
- H2 -> H3.
- H3 -> PAYLOAD.
- PAYLOAD / DROP -> H0 on an accepted LAST.
REQ-006 stream_in_READY SHALL be 1 in H0–H3 and DROP; in PAYLOAD it SHALL equal (!stream_out_VALID || stream_out_READY).
REQ-007 Header fields SHALL be captured on the beat that carries them and held stable until the next hdr_valid.
REQ-008 hdr_valid SHALL pulse one cycle after the last header beat is accepted: beat1 for ETH, beat3 for MPI.
REQ-009 Payload SHALL pass through one output register: latency 1 cycle, DATA/KEEP/LAST unchanged, no bubbles under continuous VALID and READY.
REQ-010 Once asserted, stream_out_VALID and its data SHALL be held until stream_out_READY is sampled high.
REQ-011 Header beats SHALL never appear on stream_out.
REQ-012 LAST accepted in H0, in H1 with hdr_type 2, or in H2: the block SHALL pulse err_short, suppress hdr_valid, increment frames_dropped, and return to H0.
REQ-013 LAST accepted on beat1 of an ETH frame or beat3 of an MPI frame (zero payload) SHALL still produce hdr_valid and increment frames_ok, with no output beat.
REQ-014 If FILTER_EN = 1 and dst_rank != my_rank at beat0, the frame SHALL go to DROP after its header is parsed, with hdr_valid suppressed and frames_dropped incremented.
REQ-015 frames_ok SHALL increment when a frame's LAST leaves stream_out, or per REQ-013.
REQ-016 Both counters SHALL saturate at all-ones.
REQ-017 A dropped frame SHALL increment frames_dropped exactly once, on its LAST.

Reset
REQ-018 While aresetn = 0, the block SHALL force:
- state = H0.
- stream_out_VALID = 0 and stream_in_READY = 0.
- hdr_valid, err_short, err_type = 0.
- all header field outputs = 0.
- counters = 0.
REQ-019 Reset assertion mid-frame SHALL discard the partial frame. After release, the block SHALL treat the next accepted beat as beat0.

Structure
REQ-020 Package mpi_eth_pkg SHALL hold:
- the state enum;
- HDR_TYPE_ETH = 1 and HDR_TYPE_MPI = 2;
- the beat field bit offsets.
REQ-021 The output register and its ready logic SHALL be the sub-module axis_reg_slice. The parser state machine SHALL stay in mpi_eth_rx_parser.

Verification
REQ-022 The bench SHALL cover these scenarios:
- MPI frame: my_rank = 1, dst_rank = 1, src_rank = 0, size = 16, then 2 payload beats, READY held 1 -> hdr_valid once, both payload beats output with unchanged KEEP/LAST, frames_ok = 1.
- ETH frame: type = 1, 3 payload beats, stream_out_READY toggling 1010 -> data order preserved, no beat lost or duplicated, stream_in_READY low whenever the output register is full and stalled.
- Short frame: LAST on beat1 with type = 2 -> err_short pulse, no hdr_valid, frames_dropped = 1; the next valid frame parses correctly.
- Filter: FILTER_EN = 1, my_rank = 1, dst_rank = 5 -> no hdr_valid, no output, frames_dropped +1. Type = 7 -> err_type pulse, frame dropped.
- Reset: aresetn pulsed low during a payload beat -> all outputs 0. A fresh MPI frame after release -> correct header fields.
